// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: boot/run/hold sequencing, jump/branch redirect
// selection, one-entry deferred redirect, fetch counting and misalignment flag.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Stall,
    output logic [31:0] PCResult,
    output logic        FetchValid,
    output logic [31:0] InstrCount,
    output logic        MisalignErr
);

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic              misalign_q, misalign_d;
    logic              pend_vld_q, pend_vld_d;
    logic [PC_W-1:0]   pend_tgt_q, pend_tgt_d;

    logic              redirect;
    logic [PC_W-1:0]   redirect_tgt;
    logic              load_en;
    logic [PC_W-1:0]   load_tgt;

    // Redirect arbitration: jump outranks a taken branch.
    always_comb begin
        redirect     = Jump | BranchTaken;
        redirect_tgt = Jump ? JumpTarget : BranchTarget;
    end

    // Next-state, PC source selection, pending capture and counters.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_count_d = instr_count_q;
        misalign_d    = misalign_q;
        pend_vld_d    = pend_vld_q;
        pend_tgt_d    = pend_tgt_q;
        load_en       = 1'b0;
        load_tgt      = redirect_tgt;

        unique case (state_q)
            S_BOOT: begin
                // PC stays at the reset value; an early redirect is deferred.
                state_d = S_RUN;
                if (redirect) begin
                    pend_vld_d = 1'b1;
                    pend_tgt_d = redirect_tgt;
                end
            end

            S_RUN: begin
                if (Stall) begin
                    // Stall wins over any redirect; park the redirect instead.
                    state_d = S_HOLD;
                    if (redirect) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = redirect_tgt;
                    end
                end else begin
                    instr_count_d = instr_count_q + CNT_W'(1);
                    pend_vld_d    = 1'b0;
                    if (redirect) begin
                        load_en  = 1'b1;
                        load_tgt = redirect_tgt;
                    end else if (pend_vld_q) begin
                        load_en  = 1'b1;
                        load_tgt = pend_tgt_q;
                    end else begin
                        pc_d = PCAddResult;
                    end
                end
            end

            S_HOLD: begin
                if (Stall) begin
                    if (redirect) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = redirect_tgt;
                    end
                end else begin
                    // Leaving HOLD re-steers the PC but is not itself a fetch.
                    state_d    = S_RUN;
                    pend_vld_d = 1'b0;
                    if (redirect) begin
                        load_en  = 1'b1;
                        load_tgt = redirect_tgt;
                    end else if (pend_vld_q) begin
                        load_en  = 1'b1;
                        load_tgt = pend_tgt_q;
                    end
                end
            end

            default: begin
                state_d    = S_BOOT;
                pend_vld_d = 1'b0;
            end
        endcase

        // Redirect targets are word-aligned on load; low bits flag an error.
        if (load_en) begin
            pc_d = {load_tgt[PC_W-1:2], 2'b00};
            if (load_tgt[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end

        fetch_valid_d = (state_d == S_RUN);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            instr_count_q <= '0;
            misalign_q    <= 1'b0;
            pend_vld_q    <= 1'b0;
            pend_tgt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            instr_count_q <= instr_count_d;
            misalign_q    <= misalign_d;
            pend_vld_q    <= pend_vld_d;
            pend_tgt_q    <= pend_tgt_d;
        end
    end

    assign PCResult    = pc_q;
    assign FetchValid  = fetch_valid_q;
    assign InstrCount  = instr_count_q;
    assign MisalignErr = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic, all checked
// against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_add;
    logic        jump;
    logic [31:0] jump_tgt;
    logic        br;
    logic [31:0] br_tgt;
    logic        stall;
    logic [31:0] pc;
    logic        fv;
    logic [31:0] cnt;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int          m_mode;      // 0 boot, 1 run, 2 hold
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;
    logic [31:0] pend_q[$];

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(clk), .Reset(rst), .PCAddResult(pc_add),
        .Jump(jump), .JumpTarget(jump_tgt),
        .BranchTaken(br), .BranchTarget(br_tgt),
        .Stall(stall), .PCResult(pc), .FetchValid(fv),
        .InstrCount(cnt), .MisalignErr(err)
    );

    // External PC adder.
    assign pc_add = pc + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input logic [31:0] t);
        m_pc = t & 32'hFFFF_FFFC;
        if (t[1:0] != 2'b00) m_err = 1'b1;
    endtask

    task automatic model_step();
        logic        r;
        logic [31:0] t;
        r = jump | br;
        t = jump ? jump_tgt : br_tgt;
        if (rst) begin
            m_mode = 0; m_pc = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
            pend_q.delete();
        end else if (m_mode == 0) begin
            if (r) begin pend_q.delete(); pend_q.push_back(t); end
            m_mode = 1;
        end else if (stall) begin
            if (r) begin pend_q.delete(); pend_q.push_back(t); end
            m_mode = 2;
        end else begin
            if (r) model_load(t);
            else if (pend_q.size() != 0) model_load(pend_q[0]);
            else if (m_mode == 1) m_pc = m_pc + 32'd4;
            pend_q.delete();
            if (m_mode == 1) m_cnt = m_cnt + 32'd1;
            m_mode = 1;
        end
    endtask

    // One clock: update model from the inputs seen at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("fetch_valid", 32'(fv), 32'(m_mode == 1));
        check("instr_count", cnt, m_cnt);
        check("misalign", 32'(err), 32'(m_err));
    endtask

    task automatic idle();
        jump = 1'b0; br = 1'b0; stall = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        idle(); jump_tgt = '0; br_tgt = '0;
        m_mode = 0; m_pc = '0; m_cnt = '0; m_err = 1'b0;

        // Boot and sequential fetch: PC 0,0,4,8,C.
        do_reset();
        check("reset_pc", pc, 32'h0);
        check("reset_fv", 32'(fv), 32'h0);
        repeat (4) cycle();
        check("seq_pc", pc, 32'hC);
        check("seq_cnt", cnt, 32'd3);

        // Simultaneous jump and branch at PC=8: jump wins.
        do_reset();
        repeat (3) cycle();
        jump = 1'b1; jump_tgt = 32'h40; br = 1'b1; br_tgt = 32'h80;
        cycle();
        check("jump_wins_pc", pc, 32'h40);
        check("jump_wins_cnt", cnt, 32'd3);
        idle();

        // Stall at C, newest of two held redirects applied on exit.
        do_reset();
        repeat (4) cycle();
        stall = 1'b1;
        cycle();
        check("hold_pc", pc, 32'hC);
        check("hold_fv", 32'(fv), 32'h0);
        br = 1'b1; br_tgt = 32'h100;
        cycle();
        br = 1'b0; jump = 1'b1; jump_tgt = 32'h200;
        cycle();
        check("hold_pc2", pc, 32'hC);
        jump = 1'b0; stall = 1'b0;
        cycle();
        check("hold_exit_pc", pc, 32'h200);
        check("hold_exit_cnt", cnt, 32'd3);
        check("hold_exit_fv", 32'(fv), 32'h1);

        // Misaligned jump target is aligned and the error sticks.
        jump = 1'b1; jump_tgt = 32'h43;
        cycle();
        check("misalign_pc", pc, 32'h40);
        jump = 1'b0;
        repeat (3) cycle();
        check("misalign_sticky", 32'(err), 32'h1);

        // PC wrap at the top of the address space.
        jump = 1'b1; jump_tgt = 32'hFFFF_FFFC;
        cycle();
        jump = 1'b0;
        cycle();
        check("wrap_pc", pc, 32'h0);

        // Reset during HOLD discards the pending redirect.
        stall = 1'b1;
        cycle();
        jump = 1'b1; jump_tgt = 32'h300;
        cycle();
        jump = 1'b0; stall = 1'b0; rst = 1'b1;
        cycle();
        check("hold_reset_pc", pc, 32'h0);
        check("hold_reset_err", 32'(err), 32'h0);
        rst = 1'b0;
        repeat (2) cycle();
        check("pend_dropped_pc", pc, 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] t;
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 9) < 3);
            jump  = ($urandom_range(0, 9) == 0);
            br    = ($urandom_range(0, 7) == 0);
            t = $urandom();
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            jump_tgt = t;
            t = $urandom();
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            br_tgt = t;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
